// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// Grant indices are always 3 bits wide so up to 8 requesters fit.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int GRANT_W       = 3;
  localparam int BURST_W       = 8;
  localparam int N_REQ_MIN     = 2;
  localparam int N_REQ_MAX     = 8;
  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 255;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Client-side byte streams, host flow control and the UART TX byte port,
// bundled together. The master modport belongs to the side driving requests.
interface uart_tx_arb_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
);

  // Handshake rule on both sides: a byte moves on a rising clock edge exactly
  // when valid and ready are both high; valid never waits on ready.
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               hold;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_ready;
  logic [GRANT_W-1:0] grant_id;
  logic               busy;

  modport master (
    output req_valid, req_data, req_last, hold, tx_ready,
    input  req_ready, tx_valid, tx_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, hold, tx_ready,
    output req_ready, tx_valid, tx_data, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin pick: first asserted request scanning upward
// from the slot after last_owner, wrapping at N_REQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] last_owner,
  output logic [GRANT_W-1:0] pick,
  output logic               any
);

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((i == (int'(last_owner) + k) % N_REQ) && req[i]) begin
          pick = GRANT_W'(i);
          any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX byte port among N_REQ clients.
// A grant is held for a whole message or until MAX_BURST bytes have moved.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_arb_if.slave        bus,
  output arb_state_t          state_dbg
);

  arb_state_t         state, state_next;
  logic [GRANT_W-1:0] grant_id_q;
  logic [GRANT_W-1:0] last_owner;
  logic [BURST_W-1:0] burst_cnt;
  logic               tx_valid_q;
  logic [7:0]         tx_data_q;

  logic [GRANT_W-1:0] pick;
  logic               pick_any;
  logic               slot_free;
  logic               accept;
  logic               xfer;
  logic               burst_end;
  logic [N_REQ-1:0]   ready_vec;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req        (bus.req_valid),
    .last_owner (last_owner),
    .pick       (pick),
    .any        (pick_any)
  );

  // Select the grant owner's lane.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GRANT_W'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    ready_vec  = '0;
    slot_free  = !tx_valid_q || bus.tx_ready;
    accept     = 1'b0;
    xfer       = 1'b0;
    burst_end  = (burst_cnt == BURST_W'(MAX_BURST - 1));
    case (state)
      IDLE: begin
        if (pick_any) state_next = LOCK;
      end
      LOCK: begin
        accept = slot_free && !bus.hold;
        for (int i = 0; i < N_REQ; i++) begin
          ready_vec[i] = accept && (grant_id_q == GRANT_W'(i));
        end
        xfer = accept && g_valid;
        // Forced rotation keeps the rest of the message queued at the client.
        if (xfer && (g_last || burst_end)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant_id_q <= '0;
      last_owner <= GRANT_W'(N_REQ - 1);
      burst_cnt  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_any) begin
        grant_id_q <= pick;
        burst_cnt  <= '0;
      end
      // A load in the same cycle as a drain keeps the slot full.
      if (xfer) begin
        burst_cnt  <= burst_cnt + 1'b1;
        tx_data_q  <= g_data;
        tx_valid_q <= 1'b1;
      end else if (bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      if (xfer && state_next == IDLE) last_owner <= grant_id_q;
    end
  end

  assign bus.req_ready = ready_vec;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = (state == LOCK);
  assign state_dbg     = state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random traffic checked
// against a message-level round-robin model of the expected byte order.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int N_REQ     = 4;
  localparam int MAX_BURST = 16;

  logic       clock = 1'b0;
  logic       reset;
  arb_state_t state_dbg;

  uart_tx_arb_if #(.N_REQ(N_REQ)) bus();

  uart_tx_arb #(
    .N_REQ     (N_REQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  // Per-requester pending bytes {last, data}; mdl_q is the model's copy.
  logic [8:0] src_q [N_REQ][$];
  logic [8:0] mdl_q [N_REQ][$];
  logic [7:0] exp_q[$];
  int         exp_own_q[$];
  int         tx_cyc_q[$];
  int         m_last;
  int         n_checks = 0;
  int         n_pass = 0;
  int         stall_lo = -1, stall_hi = -1;
  int         hold_lo = -1, hold_hi = -1;
  int         drain_chk_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic add_rand_msg(input int r, input int len);
    for (int j = 0; j < len; j++) add_byte(r, 8'($urandom_range(255)), j == len - 1);
  endtask

  task automatic clear_all();
    for (int r = 0; r < N_REQ; r++) begin
      src_q[r].delete();
      mdl_q[r].delete();
    end
    exp_q.delete();
    exp_own_q.delete();
  endtask

  // Grants go round-robin from the last owner among requesters with bytes
  // pending; each grant moves a message or MAX_BURST bytes, whichever is less.
  task automatic build_model();
    int  pick;
    int  cnt;
    bit  more;
    bit  done;
    logic [8:0] b;
    more = 1'b1;
    while (more) begin
      pick = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        if (pick < 0 && mdl_q[(m_last + k) % N_REQ].size() > 0) pick = (m_last + k) % N_REQ;
      end
      if (pick < 0) begin
        more = 1'b0;
      end else begin
        cnt  = 0;
        done = 1'b0;
        while (!done) begin
          b = mdl_q[pick].pop_front();
          exp_q.push_back(b[7:0]);
          exp_own_q.push_back(pick);
          cnt++;
          done = b[8] || cnt == MAX_BURST || mdl_q[pick].size() == 0;
        end
        m_last = pick;
      end
    end
  endtask

  task automatic drive_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      bus.hold      = 1'b0;
      bus.tx_ready  = 1'b1;
    end
  endtask

  task automatic run_traffic(input int rdy_pct, input int hold_pct, input int budget, input bit must_finish);
    logic       prev_stall;
    logic [7:0] prev_data;
    int         nx;
    build_model();
    tx_cyc_q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      for (int i = 0; i < N_REQ; i++) begin
        bus.req_valid[i]       = src_q[i].size() > 0;
        bus.req_last[i]        = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
        bus.req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
      end
      bus.tx_ready = $urandom_range(99) < rdy_pct;
      bus.hold     = $urandom_range(99) < hold_pct;
      if (c >= stall_lo && c < stall_hi) bus.tx_ready = 1'b0;
      if (c >= hold_lo && c < hold_hi) begin
        bus.hold     = 1'b1;
        bus.tx_ready = 1'b1;
      end
      #1;
      if (prev_stall) begin
        check("tx_stall_valid", 32'(bus.tx_valid), 1);
        check("tx_stall_data", 32'(bus.tx_data), 32'(prev_data));
      end
      if (bus.hold) check("ready_in_hold", 32'(bus.req_ready), 0);
      check("ready_onehot", 32'($countones(bus.req_ready) > 1), 0);
      if (c == drain_chk_cyc) check("drain_in_hold", 32'(bus.tx_valid), 0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          check("tx_extra", 32'(exp_q.size()), 1);
        end else begin
          check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          tx_cyc_q.push_back(c);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          if (exp_own_q.size() == 0) begin
            check("xfer_extra", 32'(exp_own_q.size()), 1);
          end else begin
            nx = exp_own_q.pop_front();
            check("xfer_owner", 32'(i), 32'(nx));
            check("grant_id", 32'(bus.grant_id), 32'(nx));
            check("busy_on_xfer", 32'(bus.busy), 1);
          end
          void'(src_q[i].pop_front());
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      if (must_finish && exp_q.size() == 0 && exp_own_q.size() == 0) break;
    end
    if (must_finish) check("run_done", 32'(exp_q.size() + exp_own_q.size()), 0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.hold      = 1'b0;
    bus.tx_ready  = 1'b0;
    m_last        = N_REQ - 1;
    clear_all();
    repeat (3) @(negedge clock);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_grant_id", 32'(bus.grant_id), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;

    // Every requester has one-byte messages, requester 0 two of them.
    add_byte(0, 8'h10, 1'b1);
    add_byte(0, 8'h11, 1'b1);
    add_byte(1, 8'h20, 1'b1);
    add_byte(2, 8'h30, 1'b1);
    add_byte(3, 8'h40, 1'b1);
    run_traffic(100, 0, 200, 1'b1);
    drive_idle(2);

    // Single requester, latency and back-to-back throughput.
    add_byte(2, 8'h41, 1'b0);
    add_byte(2, 8'h42, 1'b0);
    add_byte(2, 8'h43, 1'b1);
    run_traffic(100, 0, 100, 1'b1);
    check("lat_count", 32'(tx_cyc_q.size()), 3);
    check("lat_first", 32'(tx_cyc_q[0]), 2);
    check("lat_second", 32'(tx_cyc_q[1]), 3);
    check("lat_third", 32'(tx_cyc_q[2]), 4);
    check("busy_after_last", 32'(bus.busy), 0);
    drive_idle(2);

    // Two concurrent five-byte messages must not interleave.
    for (int j = 0; j < 5; j++) begin
      add_byte(0, 8'(8'hA0 + j), j == 4);
      add_byte(1, 8'(8'hB0 + j), j == 4);
    end
    run_traffic(100, 0, 200, 1'b1);
    drive_idle(2);

    // Burst limit: 20-byte message from 0 is split around 1's message.
    for (int j = 0; j < 20; j++) add_byte(0, 8'(j), j == 19);
    for (int j = 0; j < 3; j++) add_byte(1, 8'(8'hC0 + j), j == 2);
    run_traffic(80, 0, 500, 1'b1);
    drive_idle(2);

    // Output stall then host hold: pending byte drains under hold.
    for (int j = 0; j < 4; j++) add_byte(1, 8'(8'hD0 + j), j == 3);
    stall_lo = 0;  stall_hi = 12;
    hold_lo  = 12; hold_hi  = 17;
    drain_chk_cyc = 16;
    run_traffic(100, 0, 200, 1'b1);
    stall_lo = -1; stall_hi = -1;
    hold_lo  = -1; hold_hi  = -1;
    drain_chk_cyc = -1;
    drive_idle(2);

    // Random traffic with random output back-pressure and hold.
    for (int r = 0; r < N_REQ; r++) begin
      for (int m = 0; m < int'($urandom_range(3, 1)); m++) add_rand_msg(r, int'($urandom_range(20, 1)));
    end
    run_traffic(70, 15, 8000, 1'b1);
    drive_idle(2);

    // Reset in the middle of a message.
    add_rand_msg(2, 12);
    run_traffic(100, 0, 6, 1'b0);
    check("pre_reset_tx_valid", 32'(bus.tx_valid), 1);
    check("pre_reset_busy", 32'(bus.busy), 1);
    @(negedge clock);
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.tx_ready  = 1'b0;
    @(negedge clock);
    #1;
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 0);
    reset  = 1'b0;
    m_last = N_REQ - 1;
    clear_all();
    add_byte(3, 8'h5A, 1'b1);
    add_byte(0, 8'hA5, 1'b1);
    run_traffic(100, 0, 100, 1'b1);
    drive_idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
